axi_mem_slave: RTL
==================

Name: axi_mem_slave

Overview:
- Single-beat AXI4 target that sits directly downstream of the core-side AXI master bridge.
- Converts AW/W/B and AR/R transactions into accesses on a synchronous SRAM-style word port with 1-cycle read latency.
- Serves one transaction at a time and arbitrates fairly between reads and writes.

Parameters:
- AXI4_ADDRESS_WIDTH, 32, AXI address width.
- AXI4_ID_WIDTH, 16, AXI ID width; IDs are echoed on B/R.
- MEM_ADDR_WIDTH, 12, memory word-address width (memory size = 4*2^MEM_ADDR_WIDTH bytes).
- MEM_BASE, 32'h0000_0000, byte base address of the memory window.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- aw_id_i  in  AXI4_ID_WIDTH  write ID
- aw_addr_i  in  AXI4_ADDRESS_WIDTH  write byte address
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- w_data_i  in  32  write data
- w_strb_i  in  4  write byte strobes
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- b_id_o  out  AXI4_ID_WIDTH  response ID
- b_resp_o  out  2  write response
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- ar_id_i  in  AXI4_ID_WIDTH  read ID
- ar_addr_i  in  AXI4_ADDRESS_WIDTH  read byte address
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- r_id_o  out  AXI4_ID_WIDTH  read ID
- r_data_o  out  32  read data
- r_resp_o  out  2  read response
- r_last_o  out  1  last beat
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  1 = write
- mem_addr_o  out  MEM_ADDR_WIDTH  word address
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, valid the cycle after a read strobe

Behaviour:
- Clocking and reset:
  - One clock (clk_i); reset is synchronous and active-high (rst_i).
  - While rst_i is high: state = IDLE; all valid, ready and mem_req_o outputs = 0; ID/data/resp registers = 0; last_wr = 0.
  - rst_i asserted mid-transaction aborts the transaction; no B/R response is issued afterwards.
- FSM states: IDLE, WR_MEM, WR_RESP, RD_MEM, RD_CAP, RD_RESP.
- IDLE:
  - A write is pending only when aw_valid_i & w_valid_i.
  - If a write and ar_valid_i are both pending, serve the read when last_wr = 1, otherwise the write.
  - A lone pending request is served directly.
- Acceptance:
  - Ready outputs are asserted only in IDLE, for the selected request only.
  - aw_ready_o and w_ready_o always assert together, in the same cycle; AW or W alone is never accepted.
  - ready asserts combinationally on valid, so the handshake completes in the same cycle.
  - On handshake: capture ID, address, data and strobe into registers. Write → WR_MEM with last_wr = 1; read → RD_MEM with last_wr = 0.
- WR_MEM (1 cycle): mem_req_o = 1, mem_we_o = 1, mem_be_o/mem_wdata_o from the captured registers → WR_RESP.
- WR_RESP: b_valid_o = 1, b_resp_o = 2'b00, b_id_o = captured ID; stays until b_ready_i, then → IDLE.
- RD_MEM (1 cycle): mem_req_o = 1, mem_we_o = 0, mem_be_o = 4'hF → RD_CAP.
- RD_CAP (1 cycle): r_data register <= mem_rdata_i → RD_RESP.
- RD_RESP:
  - r_valid_o = 1, r_last_o = 1, r_resp_o = 2'b00, r_id_o = captured ID.
  - r_data_o stable until r_ready_i, then → IDLE.
- Latency:
  - Write: handshake at cycle 0 → mem write at cycle 1 → b_valid_o at cycle 2.
  - Read: handshake at cycle 0 → r_valid_o at cycle 3.
  - Back-to-back: a new handshake is possible in the cycle after the response handshake.
- Addressing: mem_addr_o = (addr - MEM_BASE)[MEM_ADDR_WIDTH+1:2]; addr[1:0] is ignored; the subtraction wraps modulo 2^AXI4_ADDRESS_WIDTH.
- Outside WR_MEM/RD_MEM: mem_req_o = 0, mem_we_o = 0.
- Memory-side outputs are driven only from registers (no combinational path from AXI inputs to mem_*).

Optional Feature:
- Macro AXI_MEM_SLAVE_DECERR_EN.
- When defined, an address outside [MEM_BASE, MEM_BASE + 4*2^MEM_ADDR_WIDTH) is decoded at handshake:
  - the memory state is skipped (mem_req_o stays 0);
  - write → WR_RESP with b_resp_o = 2'b11;
  - read → RD_RESP with r_resp_o = 2'b11, r_data_o = 0.
- When not defined: no range check; out-of-range addresses alias via truncation and always respond OKAY.

Test Plan:
- Write then read: write aw_addr 0x10, data 0xDEADBEEF, strb 0xF, with b_ready_i = 1 → mem_req/we at cycle 1 with mem_addr 4; b_valid at cycle 2, resp 0. Then read ar_addr 0x10, memory model returns 0xDEADBEEF → r_valid at cycle 3, r_data 0xDEADBEEF, r_last 1.
- Split AW/W: aw_valid_i alone for 3 cycles, then w_valid_i → aw_ready_o/w_ready_o stay 0 until w_valid_i, then both assert in the same cycle.
- Fair arbitration: write and read valid every cycle, b_ready_i/r_ready_i = 1 → grants alternate W, R, W, R; the first grant after reset is W.
- Backpressure and ID echo: r_ready_i = 0 for 5 cycles with ar_id 0x1A → r_valid_o, r_data_o and r_id_o stable for all 5 cycles; completes the cycle r_ready_i rises; no new AR accepted meanwhile.
- Reset mid-operation: rst_i high during WR_RESP → next cycle b_valid_o = 0 and state is IDLE; no B beat is seen after reset.
- AXI_MEM_SLAVE_DECERR_EN: read at MEM_BASE + 0x4000 with MEM_ADDR_WIDTH = 12 → mem_req_o never asserts; r_resp 2'b11, r_data 0.

Source files
------------

// File: rtl/axi_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_mem_slave
//
// Single-beat AXI4 target that turns AW/W/B and AR/R transactions into
// accesses on a synchronous SRAM-style word port with 1-cycle read latency.
// One transaction is in flight at a time; when a write (AW and W together)
// and a read are pending in the same cycle, the request type that was not
// served last wins.
//
// Optional feature (compile-time macro AXI_MEM_SLAVE_DECERR_EN):
//   when defined, addresses outside [MEM_BASE, MEM_BASE + 4*2^MEM_ADDR_WIDTH)
//   skip the memory access and respond with DECERR (2'b11), read data 0.
//   When undefined, addresses alias by truncation and always respond OKAY.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   aw_* / w_* / b_*        AXI4 write address, write data, write response
//   ar_* / r_*              AXI4 read address, read data
//   mem_req_o, mem_we_o     memory access strobe and write select
//   mem_addr_o              memory word address
//   mem_be_o, mem_wdata_o   byte enables and write data
//   mem_rdata_i             read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module axi_mem_slave #(
    parameter int                            AXI4_ADDRESS_WIDTH = 32,
    parameter int                            AXI4_ID_WIDTH      = 16,
    parameter int                            MEM_ADDR_WIDTH     = 12,
    parameter logic [AXI4_ADDRESS_WIDTH-1:0] MEM_BASE           = 32'h0000_0000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    // write address channel
    input  logic [AXI4_ID_WIDTH-1:0]      aw_id_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i,
    input  logic                          aw_valid_i,
    output logic                          aw_ready_o,
    // write data channel
    input  logic [31:0]                   w_data_i,
    input  logic [3:0]                    w_strb_i,
    input  logic                          w_valid_i,
    output logic                          w_ready_o,
    // write response channel
    output logic [AXI4_ID_WIDTH-1:0]      b_id_o,
    output logic [1:0]                    b_resp_o,
    output logic                          b_valid_o,
    input  logic                          b_ready_i,
    // read address channel
    input  logic [AXI4_ID_WIDTH-1:0]      ar_id_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_i,
    input  logic                          ar_valid_i,
    output logic                          ar_ready_o,
    // read data channel
    output logic [AXI4_ID_WIDTH-1:0]      r_id_o,
    output logic [31:0]                   r_data_o,
    output logic [1:0]                    r_resp_o,
    output logic                          r_last_o,
    output logic                          r_valid_o,
    input  logic                          r_ready_i,
    // memory port
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [3:0]                    mem_be_o,
    output logic [31:0]                   mem_wdata_o,
    input  logic [31:0]                   mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_MEM  = 3'd1,
        WR_RESP = 3'd2,
        RD_MEM  = 3'd3,
        RD_CAP  = 3'd4,
        RD_RESP = 3'd5
    } state_t;

    state_t                          state_r;
    state_t                          state_s;

    // last_wr_r = 1 when the most recently granted request was a write
    logic                            last_wr_r;
    logic [AXI4_ID_WIDTH-1:0]        id_r;
    logic [1:0]                      resp_r;
    logic [31:0]                     r_data_r;
    logic                            b_valid_r;
    logic                            r_valid_r;
    logic                            mem_req_r;
    logic                            mem_we_r;
    logic [MEM_ADDR_WIDTH-1:0]       mem_addr_r;
    logic [3:0]                      mem_be_r;
    logic [31:0]                     mem_wdata_r;

    logic                            wr_pend_s;
    logic                            rd_pend_s;
    logic                            sel_wr_s;
    logic                            sel_rd_s;
    logic                            wr_hs_s;
    logic                            rd_hs_s;
    logic [AXI4_ADDRESS_WIDTH-1:0]   req_addr_s;
    logic [AXI4_ADDRESS_WIDTH-1:0]   req_off_s;
    logic                            oor_s;

`ifdef AXI_MEM_SLAVE_DECERR_EN
    // Offset is computed modulo 2^AXI4_ADDRESS_WIDTH, so addresses below
    // MEM_BASE wrap to large offsets and are caught by the same test.
    function automatic logic out_of_window(input logic [AXI4_ADDRESS_WIDTH-1:0] off);
        return |off[AXI4_ADDRESS_WIDTH-1:MEM_ADDR_WIDTH+2];
    endfunction
`endif

    // Request selection and same-cycle handshake generation in IDLE
    always_comb begin
        wr_pend_s = aw_valid_i & w_valid_i;
        rd_pend_s = ar_valid_i;
        sel_wr_s  = 1'b0;
        sel_rd_s  = 1'b0;
        if (wr_pend_s && rd_pend_s) begin
            if (last_wr_r) begin
                sel_rd_s = 1'b1;
            end else begin
                sel_wr_s = 1'b1;
            end
        end else begin
            sel_wr_s = wr_pend_s;
            sel_rd_s = rd_pend_s;
        end
        // rst_i gates the readies so nothing is accepted while in reset
        wr_hs_s = (state_r == IDLE) && !rst_i && sel_wr_s;
        rd_hs_s = (state_r == IDLE) && !rst_i && sel_rd_s;
    end

    assign aw_ready_o = wr_hs_s;
    assign w_ready_o  = wr_hs_s;
    assign ar_ready_o = rd_hs_s;

    // Address translation of the granted request into the memory window
    assign req_addr_s = rd_hs_s ? ar_addr_i : aw_addr_i;
    assign req_off_s  = req_addr_s - MEM_BASE;

`ifdef AXI_MEM_SLAVE_DECERR_EN
    assign oor_s = out_of_window(req_off_s);
    logic unused_s;
    assign unused_s = ^req_off_s[1:0];
`else
    assign oor_s = 1'b0;
    logic unused_s;
    assign unused_s = ^{req_off_s[AXI4_ADDRESS_WIDTH-1:MEM_ADDR_WIDTH+2], req_off_s[1:0]};
`endif

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (wr_hs_s) begin
                    state_s = oor_s ? WR_RESP : WR_MEM;
                end else if (rd_hs_s) begin
                    state_s = oor_s ? RD_RESP : RD_MEM;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_MEM:  state_s = WR_RESP;
            WR_RESP: begin
                if (b_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = WR_RESP;
                end
            end
            RD_MEM:  state_s = RD_CAP;
            RD_CAP:  state_s = RD_RESP;
            RD_RESP: begin
                if (r_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = RD_RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus valid/strobe outputs registered from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            b_valid_r <= 1'b0;
            r_valid_r <= 1'b0;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            b_valid_r <= (state_s == WR_RESP);
            r_valid_r <= (state_s == RD_RESP);
            mem_req_r <= (state_s == WR_MEM) || (state_s == RD_MEM);
            mem_we_r  <= (state_s == WR_MEM);
        end
    end

    // Request capture at handshake and read-data capture in RD_CAP
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_wr_r   <= 1'b0;
            id_r        <= '0;
            resp_r      <= 2'b00;
            r_data_r    <= 32'h0000_0000;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'h0;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            if (wr_hs_s) begin
                last_wr_r   <= 1'b1;
                id_r        <= aw_id_i;
                resp_r      <= oor_s ? 2'b11 : 2'b00;
                mem_addr_r  <= req_off_s[MEM_ADDR_WIDTH+1:2];
                mem_be_r    <= w_strb_i;
                mem_wdata_r <= w_data_i;
            end else if (rd_hs_s) begin
                last_wr_r  <= 1'b0;
                id_r       <= ar_id_i;
                resp_r     <= oor_s ? 2'b11 : 2'b00;
                mem_addr_r <= req_off_s[MEM_ADDR_WIDTH+1:2];
                mem_be_r   <= 4'hF;
                // a decode-error read skips RD_CAP, so zero the data here
                if (oor_s) begin
                    r_data_r <= 32'h0000_0000;
                end
            end
            if (state_r == RD_CAP) begin
                r_data_r <= mem_rdata_i;
            end
        end
    end

    assign b_id_o      = id_r;
    assign b_resp_o    = resp_r;
    assign b_valid_o   = b_valid_r;
    assign r_id_o      = id_r;
    assign r_data_o    = r_data_r;
    assign r_resp_o    = resp_r;
    assign r_last_o    = r_valid_r;
    assign r_valid_o   = r_valid_r;
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_be_o    = mem_be_r;
    assign mem_wdata_o = mem_wdata_r;

endmodule
